seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Time-multiplexed scanner for the 8-digit seven-segment bank.
- Holds eight 4-bit display codes and presents one digit at a time: its code on seg_code (fed straight into the 4-bit-to-segment decoder) and a one-hot active-high digit enable on dig_en.
- Provides per-digit blanking and blinking, a guard interval against ghosting, and tear-free updates applied only on frame boundaries.
- Driven by the mode/song controller, which supplies the codes.

Parameters:
- DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= GUARD+2.
- GUARD, 4: cycles at the start of each slot during which dig_en is all-zero.
- BLINK_FRAMES, 64: full 8-digit frames per blink half-period.
- BLANK_CODE, 4'b1101: code the decoder maps to all segments off.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- codes_in  in  32  digit i code at [4i+3:4i]; digit 0 leftmost
- blank_in  in  8  bit i=1 forces digit i blank
- blink_in  in  8  bit i=1 makes digit i blink
- update  in  1  one-cycle pulse: capture codes_in/blank_in/blink_in
- seg_code  out  4  code for the active digit, to the decoder
- dig_en  out  8  one-hot active-high digit enable; all-zero during guard
- frame_start  out  1  one-cycle pulse when slot 0 begins
- pending  out  1  captured update not yet applied

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low; all registers clear immediately on assertion.
- Reset values: cnt=0, idx=0, seg_code=BLANK_CODE, dig_en=8'h00, frame_start=0, pending=0, blink_phase=0. Staging and active registers: codes=0, blank mask=8'hFF, blink mask=0.
- Slot counter: cnt counts 0..DIV-1. When cnt==DIV-1, cnt returns to 0 and idx increments modulo 8 (7 wraps to 0).
- Frame boundary: the cycle in which cnt==DIV-1 and idx==7.
- Update capture: when update=1, codes_in, blank_in and blink_in are latched into staging and pending is set to 1.
- Update apply: on a frame boundary with pending=1, staging is copied to active and pending is cleared.
- Update coincident with a frame boundary:
  - The existing staging is applied first.
  - The new values are then captured into staging.
  - pending stays 1, and the new values are applied at the following boundary.
- Repeated updates within one frame: the last update wins.
- Blink: blink_phase toggles on every BLINK_FRAMES-th frame boundary, using an internal frame counter that is reset to 0.
- Effective blank for digit i: active_blank[i] OR (active_blink[i] AND blink_phase).
- Outputs are registered with 1-cycle latency relative to cnt/idx:
  - dig_en <= (cnt >= GUARD) ? (8'b1 << idx) : 8'h00
  - seg_code <= effective blank for idx ? BLANK_CODE : active code[idx]
  - frame_start <= (cnt==0 && idx==0)
- No combinational path from inputs to outputs.
- dig_en is never multi-hot. seg_code changes only while dig_en is 0, i.e. the slot change occurs inside the guard.
- Reset mid-frame: outputs are forced to reset values asynchronously; scanning restarts at digit 0 with all digits blank until the first update is applied.
- Widths: cnt is sized as clog2(DIV); the frame counter is sized as clog2(BLINK_FRAMES). Neither counter overflows past its terminal value.

Test Plan:
- Reset/idle (DIV=10, GUARD=2): hold rst_n=0 for 5 cycles, release, run 2 frames -> dig_en walks 01,02,...,80 with each bit high for 8 of 10 cycles; seg_code=4'hD throughout; pending=0; frame_start pulses every 80 cycles.
- Update timing:
  - Stimulus: pulse update mid-frame with codes_in=32'h7654_3210, blank_in=0, blink_in=0.
  - Required: pending=1 until the next frame boundary; seg_code remains 4'hD for the current frame.
  - Next frame: slot i shows code i, i.e. 0,1,2,...,7 for digits 0..7.
- Coincident update:
  - Stimulus: update A mid-frame, then update B exactly on the boundary cycle.
  - Required: the next frame shows A, pending remains 1, and the frame after shows B.
- Blank/blink (BLINK_FRAMES=2): apply blank_in=8'h01, blink_in=8'h80 -> digit 0 always 4'hD; digit 7 alternates code/4'hD every 2 frames; other digits unaffected.
- Guard/one-hot: monitor every cycle -> popcount(dig_en)<=1 always; seg_code never changes while dig_en!=0.
- Async reset mid-slot: assert rst_n at idx=5, cnt=6 on a non-clock edge -> dig_en=0 and seg_code=4'hD immediately; after release, scanning restarts at digit 0 with pending=0.

Source files
------------

// File: rtl/seg_scan.sv
// Eight-digit seven-segment scanner: one digit per DIV-cycle slot, guard-blanked enables, double-buffered codes.
// Outputs are registered one cycle behind cnt/idx; staged updates take effect only on frame boundaries.
module seg_scan #(
  parameter int          DIV          = 100000,
  parameter int          GUARD        = 4,
  parameter int          BLINK_FRAMES = 64,
  parameter logic [3:0]  BLANK_CODE   = 4'b1101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] codes_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  blink_in,
  input  logic        update,
  output logic [3:0]  seg_code,
  output logic [7:0]  dig_en,
  output logic        frame_start,
  output logic        pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic          pend_q, pend_d;
  logic [31:0]   stg_codes_q, stg_codes_d, act_codes_q, act_codes_d;
  logic [7:0]    stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
  logic [7:0]    stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;
  logic [3:0]    seg_q, seg_d;
  logic [7:0]    en_q, en_d;
  logic          fs_q, fs_d;

  logic slot_end, boundary, eff_blank;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign boundary  = slot_end && (idx_q == 3'd7);
  assign eff_blank = act_blank_q[idx_q] | (act_blink_q[idx_q] & phase_q);

  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
    idx_d       = slot_end ? idx_q + 3'd1 : idx_q;
    frm_d       = frm_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    stg_codes_d = stg_codes_q;
    stg_blank_d = stg_blank_q;
    stg_blink_d = stg_blink_q;
    act_codes_d = act_codes_q;
    act_blank_d = act_blank_q;
    act_blink_d = act_blink_q;

    if (boundary) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
      if (pend_q) begin
        act_codes_d = stg_codes_q;
        act_blank_d = stg_blank_q;
        act_blink_d = stg_blink_q;
        pend_d      = 1'b0;
      end
    end

    // Capture after apply so a boundary-coincident update waits one more frame.
    if (update) begin
      stg_codes_d = codes_in;
      stg_blank_d = blank_in;
      stg_blink_d = blink_in;
      pend_d      = 1'b1;
    end

    en_d  = (cnt_q >= GUARD_C) ? (8'b1 << idx_q) : 8'h00;
    seg_d = eff_blank ? BLANK_CODE : act_codes_q[{idx_q, 2'b00} +: 4];
    fs_d  = (cnt_q == '0) && (idx_q == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      stg_codes_q <= '0;
      stg_blank_q <= 8'hFF;
      stg_blink_q <= 8'h00;
      act_codes_q <= '0;
      act_blank_q <= 8'hFF;
      act_blink_q <= 8'h00;
      seg_q       <= BLANK_CODE;
      en_q        <= 8'h00;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frm_q       <= frm_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      stg_codes_q <= stg_codes_d;
      stg_blank_q <= stg_blank_d;
      stg_blink_q <= stg_blink_d;
      act_codes_q <= act_codes_d;
      act_blank_q <= act_blank_d;
      act_blink_q <= act_blink_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
      fs_q        <= fs_d;
    end
  end

  assign seg_code    = seg_q;
  assign dig_en      = en_q;
  assign frame_start = fs_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: reference derives every output from the absolute cycle number since reset
// and the list of update pulses (cycle, values), using slot/frame arithmetic.
module tb_seg_scan;

  localparam int DIV = 10;
  localparam int GUARD = 2;
  localparam int BF = 2;
  localparam int FR = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] codes_in = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  blink_in = '0;
  logic        update = 1'b0;
  logic [3:0]  seg_code;
  logic [7:0]  dig_en;
  logic        frame_start;
  logic        pending;

  seg_scan #(.DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF), .BLANK_CODE(4'hD)) dut (
    .clk(clk), .rst_n(rst_n), .codes_in(codes_in), .blank_in(blank_in),
    .blink_in(blink_in), .update(update), .seg_code(seg_code), .dig_en(dig_en),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          u;
    logic [31:0] c;
    logic [7:0]  b;
    logic [7:0]  l;
  } upd_t;

  upd_t       ups[$];
  int         k;
  int         cmps;
  int         fails;
  logic [3:0] prev_seg;

  // An update sampled in cycle u is visible from this frame onward.
  function automatic int eff_frame(input int u);
    return (u + 1) / FR + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at k=%0d: got %0h, want %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dig_en"}, dig_en, 8'h00);
    chk({tag, "_seg"}, seg_code, 4'hD);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_pend"}, pending, 1'b0);
  endtask

  task automatic check();
    int          m, f, d, ph;
    logic [31:0] c;
    logic [7:0]  b, l;
    logic        pend;
    logic [3:0]  es;
    logic [7:0]  ee;
    m = k - 1;
    f = m / FR;
    d = (m / DIV) % 8;
    ph = (f / BF) % 2;
    c = '0; b = 8'hFF; l = 8'h00; pend = 1'b0;
    foreach (ups[i]) begin
      if (eff_frame(ups[i].u) <= f) begin
        c = ups[i].c; b = ups[i].b; l = ups[i].l;
      end
      if (ups[i].u < k && eff_frame(ups[i].u) * FR > k) pend = 1'b1;
    end
    es = (b[d] || (l[d] && ph == 1)) ? 4'hD : c[d*4 +: 4];
    ee = ((m % DIV) >= GUARD) ? 8'(1 << d) : 8'h00;
    chk("seg_code", seg_code, es);
    chk("dig_en", dig_en, ee);
    chk("frame_start", frame_start, (m % FR) == 0);
    chk("pending", pending, pend);
    chk("onehot", 32'($countones(dig_en) <= 1), 1);
    if (dig_en != 8'h00) chk("seg_stable_while_en", seg_code, prev_seg);
    prev_seg = seg_code;
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
    check();
  endtask

  task automatic do_update(input logic [31:0] c, input logic [7:0] b, input logic [7:0] l);
    codes_in = c; blank_in = b; blink_in = l; update = 1'b1;
    ups.push_back('{k, c, b, l});
    tick();
    update = 1'b0;
  endtask

  task automatic run_to(input int r);
    int g;
    g = 0;
    while ((k % FR) != r && g < FR) begin
      tick();
      g++;
    end
  endtask

  initial begin
    cmps = 0; fails = 0; k = 0; prev_seg = 4'hD;

    // Reset and idle scanning
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    check_reset_vals("reset");
    repeat (2 * FR) tick();

    // Mid-frame update
    run_to(30);
    do_update(32'h7654_3210, 8'h00, 8'h00);
    repeat (2 * FR) tick();

    // Update A mid-frame, B on the boundary cycle
    run_to(25);
    do_update($urandom, 8'h00, 8'h00);
    run_to(FR - 1);
    do_update($urandom, 8'h00, 8'h00);
    repeat (3 * FR) tick();

    // Blank digit 0, blink digit 7
    run_to(40);
    do_update(32'hFEDC_BA98, 8'h01, 8'h80);
    repeat (6 * FR) tick();

    // Random update traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0)
        do_update($urandom, 8'($urandom & $urandom), 8'($urandom));
      else
        tick();
    end

    // Asynchronous reset at idx=5, cnt=6, away from the clock edge
    run_to(56);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("held_rst");
    rst_n = 1'b1;
    k = 0;
    ups.delete();
    prev_seg = 4'hD;
    repeat (FR + 20) tick();
    do_update($urandom, 8'h00, 8'h00);
    repeat (2 * FR) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
